// File: rtl/md_issue_ctrl.sv
// ============================================================================
//  Module      : md_issue_ctrl
//  Description : Issue/hazard controller for the HI/LO multiply-divide unit.
//                Owns the busy countdown, gates unit strobes, stalls D stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_md_op,
    input  logic             e_is_div,
    input  logic             e_mt_op,
    input  logic             d_uses_hilo,
    input  logic             flush,
    output logic             md_start,
    output logic             md_enable,
    output logic             busy,
    output logic             done,
    output logic             stall_D,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] C_MULT_LAT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] C_DIV_LAT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ZERO     = '0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_run;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= C_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_enable = ~flush;
        md_start  = e_md_op & ~flush & (state_q == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (md_start) begin
                    state_d = S_RUN;
                    cnt_d   = e_is_div ? C_DIV_LAT : C_MULT_LAT;
                end
            end
            S_RUN: begin
                // A flush here never cancels the countdown: the op already committed.
                if (cnt_q <= C_ONE) begin
                    state_d = S_IDLE;
                    cnt_d   = C_ZERO;
                end else begin
                    cnt_d   = cnt_q - C_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = C_ZERO;
            end
        endcase
    end

    // Status outputs are masked while reset is held so nothing leaks mid-reset.
    assign w_run   = (state_q == S_RUN) & ~reset;
    assign busy    = w_run;
    assign done    = w_run & (cnt_q == C_ONE);
    assign stall_D = d_uses_hilo & (w_run | (md_start & ~reset));
    assign cnt     = cnt_q;

    // One E-stage instruction cannot be both a mult/div and an mthi/mtlo,
    // and a mult/div must never reach E while the unit is still running.
    a_e_op_exclusive : assert property (@(posedge clk) disable iff (reset)
        !(e_md_op && e_mt_op));
    a_no_md_op_in_run : assert property (@(posedge clk) disable iff (reset)
        !(e_md_op && (state_q == S_RUN)));

endmodule

`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
// ============================================================================
//  Module      : tb_md_issue_ctrl
//  Description : Self-checking bench for md_issue_ctrl with a countdown model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_issue_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             e_md_op, e_is_div, e_mt_op, d_uses_hilo, flush;
    logic             md_start, md_enable, busy, done, stall_D;
    logic [CNT_W-1:0] cnt;

    int n_checks = 0;
    int n_errors = 0;
    int rem      = 0;   // model: remaining busy cycles of the in-flight op

    always #5 clk = ~clk;

    md_issue_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .e_md_op     (e_md_op),
        .e_is_div    (e_is_div),
        .e_mt_op     (e_mt_op),
        .d_uses_hilo (d_uses_hilo),
        .flush       (flush),
        .md_start    (md_start),
        .md_enable   (md_enable),
        .busy        (busy),
        .done        (done),
        .stall_D     (stall_D),
        .cnt         (cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance the model.
    task automatic step(input logic rst, input logic md, input logic dv, input logic mt,
                        input logic dh, input logic fl);
        logic exp_start, exp_busy, exp_done, exp_stall;
        @(posedge clk);
        #1;
        reset = rst; e_md_op = md; e_is_div = dv; e_mt_op = mt; d_uses_hilo = dh; flush = fl;
        #3;
        exp_start = md && !fl && (rem == 0);
        exp_busy  = !rst && (rem > 0);
        exp_done  = !rst && (rem == 1);
        exp_stall = !rst && dh && (exp_busy || exp_start);
        check_eq("busy", 32'(busy), 32'(exp_busy));
        check_eq("done", 32'(done), 32'(exp_done));
        check_eq("stall_D", 32'(stall_D), 32'(exp_stall));
        check_eq("cnt", 32'(cnt), 32'(rem));
        if (!rst) begin
            check_eq("md_start", 32'(md_start), 32'(exp_start));
            check_eq("md_enable", 32'(md_enable), 32'(!fl));
        end
        if (rst)            rem = 0;
        else if (rem > 0)   rem = rem - 1;
        else if (exp_start) rem = dv ? DIV_LAT : MULT_LAT;
    endtask

    task automatic idle_cycles(input int n, input logic dh);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, dh, 1'b0);
    endtask

    initial begin
        reset = 1'b1; e_md_op = 1'b0; e_is_div = 1'b0; e_mt_op = 1'b0;
        d_uses_hilo = 1'b0; flush = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(2, 1'b1);

        // mult, no flush
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(7, 1'b0);

        // div with mflo in D throughout
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_cycles(12, 1'b1);

        // flushed mult
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_cycles(3, 1'b1);

        // div with flush on busy cycle 3
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_cycles(9, 1'b0);

        // reset on busy cycle 4 of a mult, then a fresh mult
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(7, 1'b0);

        // mtlo without and with flush
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_cycles(2, 1'b0);

        // randomized traffic; mult/div only offered while the model is idle
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_md, r_dv, r_mt, r_dh, r_fl;
            r_rst = ($urandom_range(0, 63) == 0);
            r_md  = (rem == 0) && ($urandom_range(0, 3) == 0);
            r_dv  = 1'($urandom);
            r_mt  = !r_md && ($urandom_range(0, 3) == 0);
            r_dh  = 1'($urandom);
            r_fl  = ($urandom_range(0, 7) == 0);
            step(r_rst, r_md, r_dv, r_mt, r_dh, r_fl);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
